fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer for async_fifo. Runs in the FIFO read-clock domain.
- Drains 4-bit entries through the FIFO read port (rd_en/rdata/empty).
- Packs RATIO consecutive entries into one wide word and presents it on a valid/ready output.
- A flush request emits a partial word with a nibble-valid count.

Parameters:
- WIDTH, 4, FIFO entry width (bits); must match async_fifo WIDTH.
- RATIO, 4, entries per output word; 2..8.
- OUT_WIDTH, WIDTH*RATIO, output word width; derived, never overridden.
- CNT_W, $clog2(RATIO+1), width of the count fields.

Ports:
- clk_i  input  1  read-side clock; same clock as async_fifo rd_clk_i.
- rst_i  input  1  asynchronous, active-low reset; 0 = reset.
- empty_i  input  1  async_fifo empty_o.
- rdata_i  input  WIDTH  async_fifo rdata_o.
- fifo_err_i  input  1  async_fifo error_o.
- rd_en_o  output  1  pop request to async_fifo rd_en_i.
- flush_i  input  1  single-cycle request to emit the partial word.
- out_data_o  output  OUT_WIDTH  packed word; first-popped entry in bits [WIDTH-1:0].
- out_cnt_o  output  CNT_W  number of valid entries in out_data_o (1..RATIO).
- out_valid_o  output  1  out_data_o and out_cnt_o are valid.
- out_ready_i  input  1  consumer accepts the word this cycle.
- err_o  output  1  sticky error flag.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - rd_en_o=0, out_valid_o=0, out_data_o=0, out_cnt_o=0, err_o=0.
  - Accumulator, cnt and pend are cleared; state=FILL.
  - Any in-flight pop is discarded.
  - Reset mid-word loses the partial data; no word is emitted.
- FIFO timing contract: rdata_i is valid on the cycle after a cycle with rd_en_o=1 and empty_i=0.
- Internal state:
  - cnt = entries held in the accumulator (0..RATIO).
  - pend = 1 when a pop was accepted last cycle.
- rd_en_o is combinational: rd_en_o = !empty_i && state==FILL && (cnt+pend < RATIO) && !flush_pending. It is never asserted while empty_i=1.
- Capture: when pend=1, rdata_i is written to accumulator slot cnt and cnt increments in the same edge.
- FSM states: FILL, HOLD.
  - FILL -> HOLD: cnt reaches RATIO, or a flush is pending with pend=0 and cnt>0.
  - HOLD: if out_valid_o=0, or out_valid_o && out_ready_i, the accumulator loads the output register. The load sets out_cnt_o=cnt and out_valid_o=1, and zero-fills unused nibbles. Then cnt=0 and state=FILL.
  - HOLD otherwise waits; no pops are issued.
- Output register:
  - out_valid_o stays high until out_ready_i=1.
  - out_data_o and out_cnt_o are stable while out_valid_o=1 and out_ready_i=0.
  - Accept with no new load clears out_valid_o next cycle.
  - Back-to-back accept and load keeps out_valid_o=1 with the new data.
- Latency: last entry pop to out_valid_o rising = 3 clk_i edges (pop, capture, load), with the output register free.
- Throughput: with out_ready_i=1 and a non-empty FIFO, one word per RATIO+2 cycles.
- Flush:
  - flush_i sets flush_pending, which is held until serviced.
  - With cnt=0 and pend=0, flush_pending clears with no output.
  - With cnt>0, a partial word is emitted once the in-flight pop (if any) has been captured.
  - flush_i during HOLD with cnt=RATIO: the full word is emitted, then flush_pending clears with no output.
- Error: err_o is set on fifo_err_i=1 and cleared only by reset. Data flow is unaffected.

Test Plan:
- Release reset, write nibbles 1,2,3,4 into async_fifo, out_ready_i=1 -> one word: out_data_o=16'h4321, out_cnt_o=4, out_valid_o high for exactly 1 cycle.
- Write 16 entries 0..F, out_ready_i=1 -> words 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC in order. empty_i then rises; rd_en_o is never high while empty_i=1.
- out_ready_i=0 while 8 entries are queued -> first word is held stable. Exactly 4 further pops, then rd_en_o=0. Raising out_ready_i releases 16'h3210, then 16'h7654, with no loss.
- Write 5,6,7, then pulse flush_i -> out_data_o=16'h0765, out_cnt_o=3. A second flush_i with an empty accumulator produces no output.
- Assert rst_i=0 with 2 entries captured and out_valid_o=1 -> all outputs 0 immediately (asynchronous). After release, the next 4 entries form a clean word.
- Pulse fifo_err_i for 1 cycle -> err_o=1 and stays 1 through further traffic, until reset.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side packer for async_fifo: drains narrow entries, packs RATIO of them into one wide word,
// and presents it on a valid/ready port; a flush request emits a partial word with its entry count.
module fifo_rd_packer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned OUT_WIDTH = WIDTH * RATIO,
    parameter int unsigned CNT_W     = $clog2(RATIO + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 empty_i,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 fifo_err_i,
    output logic                 rd_en_o,
    input  logic                 flush_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0]     out_cnt_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 err_o
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    localparam logic [CNT_W:0]   RatioExt = (CNT_W + 1)'(RATIO);
    localparam logic [CNT_W-1:0] RatioCnt = CNT_W'(RATIO);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   flush_q, flush_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   err_q, err_d;
    logic                   load;
    logic [CNT_W:0]         committed;

    // Entries held plus the one in flight must leave room in the accumulator.
    assign committed = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    assign rd_en_o   = !empty_i && (state_q == StFill) && (committed < RatioExt) && !flush_q;
    assign load      = (state_q == StHold) && (!out_valid_q || out_ready_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = rd_en_o;
        flush_d     = flush_q | flush_i;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        err_d       = err_q | fifo_err_i;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StFill: begin
                if (pend_q) begin
                    acc_d[cnt_q*WIDTH +: WIDTH] = rdata_i;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_d == RatioCnt) begin
                    state_d = StHold;
                end else if (flush_q && !pend_q) begin
                    if (cnt_q != '0) begin
                        state_d = StHold;
                    end else begin
                        flush_d = flush_i;
                    end
                end
            end
            StHold: begin
                if (load) begin
                    out_data_d  = acc_q;
                    out_cnt_d   = cnt_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;   // keeps unused slots zero for the next partial word
                    cnt_d       = '0;
                    state_d     = StFill;
                    // A full word leaves any flush pending; it then retires with no output.
                    if (cnt_q != RatioCnt) begin
                        flush_d = flush_i;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            flush_q     <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            flush_q     <= flush_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_cnt_o   = out_cnt_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: behavioural FIFO source, scoreboard of expected words.
module tb_fifo_rd_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        empty_i;
    logic [3:0]  rdata_i = 4'h0;
    logic        fifo_err_i = 1'b0;
    logic        rd_en_o;
    logic        flush_i = 1'b0;
    logic [15:0] out_data_o;
    logic [2:0]  out_cnt_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        err_o;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] fmem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_cnt = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    fifo_rd_packer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .empty_i     (empty_i),
        .rdata_i     (rdata_i),
        .fifo_err_i  (fifo_err_i),
        .rd_en_o     (rd_en_o),
        .flush_i     (flush_i),
        .out_data_o  (out_data_o),
        .out_cnt_o   (out_cnt_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    assign empty_i = (wr_ptr == rd_ptr);

    // FIFO read port: data appears the cycle after an accepted pop.
    always @(posedge clk_i) begin
        if (rd_en_o && !empty_i) begin
            rdata_i <= fmem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor and pop-while-empty guard, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (rd_en_o && empty_i) begin
            check("rd_en_while_empty", 32'(rd_en_o), 32'd0);
        end
        if (rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {16'h0, out_data_o}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_data", {16'h0, out_data_o}, {16'h0, e.data});
                check("word_cnt", {29'h0, out_cnt_o}, {29'h0, e.cnt});
            end
        end
    end

    task automatic push(input logic [3:0] v);
        fmem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [2:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && empty_i && !out_valid_o) done = 1'b1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
        check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_data"}, {16'h0, out_data_o}, 32'd0);
        check({tag, "_cnt"}, {29'h0, out_cnt_o}, 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        int base;

        // Reset state
        cycles(2);
        check_reset_outputs("reset");
        rst_i = 1'b1;
        cycles(2);

        // Single word 4321
        out_ready_i = 1'b1;
        expect_word(16'h4321, 3'd4);
        for (int i = 1; i <= 4; i++) push(4'(i));
        drain("drain_single");

        // Four words from 0..F
        expect_word(16'h3210, 3'd4);
        expect_word(16'h7654, 3'd4);
        expect_word(16'hBA98, 3'd4);
        expect_word(16'hFEDC, 3'd4);
        for (int i = 0; i < 16; i++) push(4'(i));
        drain("drain_stream");
        check("idle_rd_en", 32'(rd_en_o), 32'd0);

        // Backpressure: first word held, accumulator refills, then pops stop
        out_ready_i = 1'b0;
        base = pop_cnt;
        expect_word(16'h3210, 3'd4);
        expect_word(16'h7654, 3'd4);
        expect_word(16'hBA98, 3'd4);
        for (int i = 0; i < 12; i++) push(4'(i));
        cycles(20);
        check("hold_valid", 32'(out_valid_o), 32'd1);
        check("hold_data_a", {16'h0, out_data_o}, 32'h3210);
        check("hold_pops", 32'(pop_cnt - base), 32'd8);
        check("hold_rd_en", 32'(rd_en_o), 32'd0);
        check("hold_not_empty", 32'(empty_i), 32'd0);
        cycles(5);
        check("hold_data_b", {16'h0, out_data_o}, 32'h3210);
        check("hold_cnt_b", {29'h0, out_cnt_o}, 32'd4);
        out_ready_i = 1'b1;
        drain("drain_backpressure");

        // Partial flush, then a flush with nothing held
        out_ready_i = 1'b1;
        push(4'h5);
        push(4'h6);
        push(4'h7);
        cycles(8);
        check("preflush_valid", 32'(out_valid_o), 32'd0);
        expect_word(16'h0765, 3'd3);
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0;
        drain("drain_flush");
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0;
        cycles(10);
        check("empty_flush_valid", 32'(out_valid_o), 32'd0);

        // Asynchronous reset with a word held and two entries captured
        out_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) push(4'(i));
        cycles(15);
        check("prereset_valid", 32'(out_valid_o), 32'd1);
        check("prereset_data", {16'h0, out_data_o}, 32'h4321);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        expect_word(16'hCBA9, 3'd4);
        push(4'h9);
        push(4'hA);
        push(4'hB);
        push(4'hC);
        drain("drain_after_reset");

        // Sticky error
        fifo_err_i = 1'b1;
        cycles(1);
        fifo_err_i = 1'b0;
        cycles(1);
        check("err_set", 32'(err_o), 32'd1);
        expect_word(16'h8421, 3'd4);
        push(4'h1);
        push(4'h2);
        push(4'h4);
        push(4'h8);
        drain("drain_with_err");
        check("err_sticky", 32'(err_o), 32'd1);
        rst_i = 1'b0;
        cycles(1);
        check("err_cleared", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
